sum_pipe: RTL and testbench



---
 rtl/sum_pkg.sv | 12 +
 rtl/sum_seg.sv | 56 +++++
 rtl/sum_pipe.sv | 176 +++++++++++++++++
 tb/tb_sum_pipe.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_pkg.sv
// sum_pkg: shared defaults and helpers for the segmented pipelined adder.
package sum_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG_W = 4;

    // Number of carry segments, i.e. pipeline depth (ceiling division).
    function automatic int seg_count(input int width, input int seg_w);
        return (width + seg_w - 1) / seg_w;
    endfunction

endpackage

// File: rtl/sum_seg.sv
// sum_seg: one registered carry segment of sum_pipe. Adds a segment of the
// operands plus the incoming carry and registers the result, carry-out and
// the beat's valid bit. Everything holds while en is low.
module sum_seg
    import sum_pkg::*;
#(
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             vld_in,
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout,
    output logic             vld_out
);

    logic [SEG_W-1:0] s_d;
    logic [SEG_W-1:0] s_q;
    logic             cout_d;
    logic             cout_q;
    logic             vld_d;
    logic             vld_q;

    // Segment addition; hold the previous contents while stalled.
    always_comb begin
        s_d    = s_q;
        cout_d = cout_q;
        vld_d  = vld_q;
        if (en) begin
            {cout_d, s_d} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
            vld_d         = vld_in;
        end
    end

    // Segment result register; reset clears data too so outputs are never X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            vld_q  <= vld_d;
        end
    end

    assign s       = s_q;
    assign cout    = cout_q;
    assign vld_out = vld_q;

endmodule

// File: rtl/sum_pipe.sv
// sum_pipe: pipelined WIDTH-bit add/subtract with carry-in and valid/ready
// handshakes. The carry chain is cut into SEG_W-bit segments, one register
// stage each, so latency is STAGES = ceil(WIDTH/SEG_W) cycles.
// Optional feature macro: SUM_PIPE_OVF_EN adds the signed-overflow output ovf.
module sum_pipe
    import sum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SUM_PIPE_OVF_EN
    output logic             ovf,
`endif
    output logic             c_out
);

    localparam int STAGES = seg_count(WIDTH, SEG_W);

    logic             stall;
    logic             en;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Handshake: the whole pipe freezes only when a result is held at the output.
    // Subtraction is A + ~B + 1, so B is inverted and the carry forced at capture.
    always_comb begin
        stall    = out_valid & ~out_ready;
        en       = ~stall;
        in_ready = ~stall;
        accept   = in_valid & ~stall;
        b_eff    = sub ? ~data_b : data_b;
        cin_eff  = sub | c_in;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG_W;
        localparam int HI = (LO + SEG_W > WIDTH) ? WIDTH : LO + SEG_W;
        localparam int SW = HI - LO;

        // Operand bits still to be added (segment k and above), and the
        // result bits known after this stage (segments 0..k).
        logic [WIDTH-LO-1:0] op_a;
        logic [WIDTH-LO-1:0] op_b;
        logic [HI-1:0]       res_out;
        logic [SW-1:0]       seg_s;
        logic                seg_cin;
        logic                seg_cout;
        logic                seg_vin;
        logic                seg_vout;

        if (k == 0) begin : g_src
            assign op_a    = data_a;
            assign op_b    = b_eff;
            assign seg_cin = cin_eff;
            assign seg_vin = accept;
            assign res_out = seg_s;
        end else begin : g_src
            logic [LO-1:0] lo_d;
            logic [LO-1:0] lo_q;

            assign op_a    = g_stage[k-1].g_skew.a_up_q;
            assign op_b    = g_stage[k-1].g_skew.b_up_q;
            assign seg_cin = g_stage[k-1].seg_cout;
            assign seg_vin = g_stage[k-1].seg_vout;

            // Carry the already-finished lower result bits alongside the beat.
            always_comb begin
                lo_d = lo_q;
                if (en) begin
                    lo_d = g_stage[k-1].res_out;
                end
            end

            // Lower-result alignment register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lo_q <= '0;
                end else begin
                    lo_q <= lo_d;
                end
            end

            assign res_out = {seg_s, lo_q};
        end

        sum_seg #(
            .SEG_W(SW)
        ) u_seg (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .vld_in (seg_vin),
            .a      (op_a[SW-1:0]),
            .b      (op_b[SW-1:0]),
            .cin    (seg_cin),
            .s      (seg_s),
            .cout   (seg_cout),
            .vld_out(seg_vout)
        );

        if (HI < WIDTH) begin : g_skew
            logic [WIDTH-HI-1:0] a_up_d;
            logic [WIDTH-HI-1:0] a_up_q;
            logic [WIDTH-HI-1:0] b_up_d;
            logic [WIDTH-HI-1:0] b_up_q;

            // Delay the not-yet-added operand bits so they meet their carry.
            always_comb begin
                a_up_d = a_up_q;
                b_up_d = b_up_q;
                if (en) begin
                    a_up_d = op_a[WIDTH-LO-1:SW];
                    b_up_d = op_b[WIDTH-LO-1:SW];
                end
            end

            // Operand skew register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_up_q <= '0;
                    b_up_q <= '0;
                end else begin
                    a_up_q <= a_up_d;
                    b_up_q <= b_up_d;
                end
            end
        end

`ifdef SUM_PIPE_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic x_d;
            logic x_q;

            // Keep the operand MSB parity; with the registered sum MSB it
            // recovers the carry into the MSB without a second adder.
            always_comb begin
                x_d = x_q;
                if (en) begin
                    x_d = op_a[SW-1] ^ op_b[SW-1];
                end
            end

            // MSB parity register, aligned with the last result segment.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    x_q <= 1'b0;
                end else begin
                    x_q <= x_d;
                end
            end
        end
`endif
    end

    assign sum       = g_stage[STAGES-1].res_out;
    assign c_out     = g_stage[STAGES-1].seg_cout;
    assign out_valid = g_stage[STAGES-1].seg_vout;

`ifdef SUM_PIPE_OVF_EN
    // Signed overflow = carry into MSB xor carry out of MSB.
    assign ovf = g_stage[STAGES-1].g_ovf.x_q ^ sum[WIDTH-1] ^ c_out;
`endif

endmodule

// File: tb/tb_sum_pipe.sv
// tb_sum_pipe: directed-vector bench for sum_pipe with a scoreboard model.
// Two instances: WIDTH=4/SEG_W=1 (exhaustive sweep) and WIDTH=16/SEG_W=4.
`timescale 1ns/1ps
module tb_sum_pipe;

    localparam int W4   = 4;
    localparam int ST4  = 4;
    localparam int W16  = 16;
    localparam int ST16 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       iv4, ir4, ov4, or4, cin4, sub4, co4, ovf4;
    logic [3:0] a4, b4, s4;
    logic        iv16, ir16, ov16, or16, cin16, sub16, co16, ovf16;
    logic [15:0] a16, b16, s16;

    sum_pipe #(.WIDTH(4), .SEG_W(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .data_a(a4), .data_b(b4), .c_in(cin4), .sub(sub4),
        .out_valid(ov4), .out_ready(or4), .sum(s4),
`ifdef SUM_PIPE_OVF_EN
        .ovf(ovf4),
`endif
        .c_out(co4)
    );

    sum_pipe #(.WIDTH(16), .SEG_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .data_a(a16), .data_b(b16), .c_in(cin16), .sub(sub16),
        .out_valid(ov16), .out_ready(or16), .sum(s16),
`ifdef SUM_PIPE_OVF_EN
        .ovf(ovf16),
`endif
        .c_out(co16)
    );

`ifndef SUM_PIPE_OVF_EN
    assign ovf4  = 1'b0;
    assign ovf16 = 1'b0;
`endif

    typedef struct {
        int res;
        bit ovf;
        int acc_cyc;
        int acc_stall;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit rst_low_prev = 1'b0;
    int stall_tot[2];
    bit prev_stall[2];
    bit head_seen[2];
    int prev_s[2];
    bit prev_co[2];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic: {c_out,sum} as an integer.
    function automatic int exp_res(input int w, input int a, input int b, input bit cin, input bit sub);
        int m;
        m = (1 << w) - 1;
        if (sub) return ((a >= b) ? (1 << w) : 0) | ((a - b) & m);
        return a + b + int'(cin);
    endfunction

    // Reference signed overflow: true result outside the signed range.
    function automatic bit exp_ovf(input int w, input int a, input int b, input bit cin, input bit sub);
        int h, sa, sb, r;
        h  = 1 << (w - 1);
        sa = (a >= h) ? a - 2 * h : a;
        sb = (b >= h) ? b - 2 * h : b;
        r  = sub ? sa - sb : sa + sb + int'(cin);
        return (r >= h) || (r < -h);
    endfunction

    task automatic pin(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_fail++;
            $display("FAIL pin_%s: model gives %h, required %h", name, got, req);
        end
    endtask

    task automatic check_dut(input int id, input int w, input int st, input bit iv, input bit ir,
                             input bit ov, input bit ordy, input int a, input int b, input bit cin,
                             input bit sub, input int s, input bit co, input bit ovf_v);
        beat_t h;
        beat_t nb;
        bit    have;
        int    got;
        int    lat_exp;
        if (rst_low_prev) begin
            n_cmp++;
            if (ov || s != 0 || co) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: valid=%0d sum=%h c_out=%0d, required 0/0/0", id, ov, s, co);
            end
        end else if (prev_stall[id]) begin
            n_cmp++;
            if (!ov || s != prev_s[id] || co != prev_co[id]) begin
                n_fail++;
                $display("FAIL stall_hold dut%0d: valid=%0d sum=%h c_out=%0d, required 1 %h %0d",
                         id, ov, s, co, prev_s[id], prev_co[id]);
            end
        end
        if (!rst_n) begin
            if (id == 0) q0.delete(); else q1.delete();
            head_seen[id]  = 1'b0;
            prev_stall[id] = 1'b0;
            return;
        end
        n_cmp++;
        if (ir != !(ov && !ordy)) begin
            n_fail++;
            $display("FAIL in_ready dut%0d: got %0d, required %0d", id, ir, !(ov && !ordy));
        end
        if (ov) begin
            have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
            n_cmp++;
            if (!have) begin
                n_fail++;
                $display("FAIL spurious dut%0d: out_valid with sum=%h c_out=%0d, required no output", id, s, co);
            end else begin
                h   = (id == 0) ? q0[0] : q1[0];
                got = (int'(co) << w) | s;
                if (got != h.res) begin
                    n_fail++;
                    $display("FAIL result dut%0d: got %h, required %h", id, got, h.res);
                end
`ifdef SUM_PIPE_OVF_EN
                n_cmp++;
                if (ovf_v != h.ovf) begin
                    n_fail++;
                    $display("FAIL ovf dut%0d: got %0d, required %0d", id, ovf_v, h.ovf);
                end
`endif
                if (!head_seen[id]) begin
                    lat_exp = h.acc_cyc + st + (stall_tot[id] - h.acc_stall);
                    n_cmp++;
                    if (cyc != lat_exp) begin
                        n_fail++;
                        $display("FAIL latency dut%0d: presented at cycle %0d, required %0d", id, cyc, lat_exp);
                    end
                    head_seen[id] = 1'b1;
                end
                if (ordy) begin
                    if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    head_seen[id] = 1'b0;
                end
            end
        end
        if (iv && ir) begin
            nb.res       = exp_res(w, a, b, cin, sub);
            nb.ovf       = exp_ovf(w, a, b, cin, sub);
            nb.acc_cyc   = cyc;
            nb.acc_stall = stall_tot[id];
            if (id == 0) q0.push_back(nb); else q1.push_back(nb);
        end
        prev_stall[id] = ov && !ordy;
        if (prev_stall[id]) stall_tot[id]++;
        prev_s[id]  = s;
        prev_co[id] = co;
        if (ovf_v === 1'bx) $display("note: ovf unknown");
    endtask

    // Single compare process for both instances, sampled on the falling edge.
    always @(negedge clk) begin
        check_dut(0, W4, ST4, iv4, ir4, ov4, or4, int'(a4), int'(b4), cin4, sub4, int'(s4), co4, ovf4);
        check_dut(1, W16, ST16, iv16, ir16, ov16, or16, int'(a16), int'(b16), cin16, sub16, int'(s16), co16, ovf16);
        rst_low_prev = !rst_n;
    end

    task automatic send(input int id, input int a, input int b, input bit cin, input bit sub);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        if (id == 0) begin
            iv4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; cin4 = cin; sub4 = sub;
        end else begin
            iv16 = 1'b1; a16 = a[15:0]; b16 = b[15:0]; cin16 = cin; sub16 = sub;
        end
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = (id == 0) ? ir4 : ir16;
            n++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout dut%0d: in_ready stayed 0 for %0d cycles, required 1", id, n);
        end
        if (id == 0) iv4 = 1'b0; else iv16 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        iv4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0; or4 = 1;
        iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; or16 = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Hand-computed expectations pinning the model.
        pin("ffff_plus_1", exp_res(16, 'hFFFF, 'h0001, 0, 0), 'h10000);
        pin("1234_plus_4321", exp_res(16, 'h1234, 'h4321, 0, 0), 'h05555);
        pin("8000_plus_8000", exp_res(16, 'h8000, 'h8000, 0, 0), 'h10000);
        pin("5_minus_7", exp_res(16, 5, 7, 0, 1), 'h0FFFE);
        pin("7_minus_5", exp_res(16, 7, 5, 0, 1), 'h10002);
        pin("0_minus_0", exp_res(16, 0, 0, 0, 1), 'h10000);
        pin("f_plus_f_c1", exp_res(4, 15, 15, 1, 0), 'h1F);
        pin("ovf_7fff_plus_1", int'(exp_ovf(16, 'h7FFF, 1, 0, 0)), 1);
        pin("ovf_8000_minus_1", int'(exp_ovf(16, 'h8000, 1, 0, 1)), 1);
        pin("ovf_1_plus_1", int'(exp_ovf(16, 1, 1, 0, 0)), 0);

        // Exhaustive 4-bit sweep, back-to-back, both carry-in values.
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    send(0, a, b, c[0], 1'b0);
        idle(8);

        // 16-bit back-to-back adds then subtracts.
        send(1, 'hFFFF, 'h0001, 0, 0);
        send(1, 'h1234, 'h4321, 0, 0);
        send(1, 'h8000, 'h8000, 0, 0);
        send(1, 5, 7, 0, 1);
        send(1, 7, 5, 0, 1);
        send(1, 0, 0, 0, 1);
        idle(8);

        // Backpressure: 8 beats with out_ready low for 3 cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(1, (i * 'h2345 + 'h1111) & 'hFFFF, ('hFEDC - i * 'h1357) & 'hFFFF, i[0], i[1]);
            end
            begin
                idle(5);
                or16 = 1'b0;
                idle(3);
                or16 = 1'b1;
            end
        join
        idle(10);

        // Reset with three beats in flight; none of them may emerge.
        send(1, 'h1111, 'h2222, 0, 0);
        send(1, 'h3333, 'h4444, 1, 0);
        send(1, 'h9999, 'h1111, 0, 1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(10);

        // Signed-overflow vectors.
        send(1, 'h7FFF, 'h0001, 0, 0);
        send(1, 'h8000, 'h0001, 0, 1);
        send(1, 'h0001, 'h0001, 0, 0);
        idle(10);

        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d results undelivered, required 0/0", q0.size(), q1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
